// File: rtl/operand_fetch_pkg.sv
// Shared widths and ALU control codes for the operand fetch stage and the ALU it feeds.
package operand_fetch_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

endpackage

// File: rtl/operand_fetch_regfile.sv
// Register file: two read ports, one write port, x0 hardwired to zero,
// and same-cycle write-through so a reader never sees a stale value.
module regfile
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W = operand_fetch_pkg::DATA_W,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_raddr1,
    input  logic [ADDR_W-1:0] i_raddr2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata
);

    logic [DATA_W-1:0] r_mem [NREG];
    logic              w_wr_ok;

    assign w_wr_ok = i_we && (i_waddr != '0) && (int'(i_waddr) < NREG);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
        end else if (w_wr_ok) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Bypass is checked before the array so a same-cycle writeback wins.
    always_comb begin
        o_rdata1 = '0;
        if (i_raddr1 == '0 || int'(i_raddr1) >= NREG) o_rdata1 = '0;
        else if (w_wr_ok && i_waddr == i_raddr1)      o_rdata1 = i_wdata;
        else                                          o_rdata1 = r_mem[i_raddr1];
    end

    always_comb begin
        o_rdata2 = '0;
        if (i_raddr2 == '0 || int'(i_raddr2) >= NREG) o_rdata2 = '0;
        else if (w_wr_ok && i_waddr == i_raddr2)      o_rdata2 = i_wdata;
        else                                          o_rdata2 = r_mem[i_raddr2];
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: reads the register file (or immediate) and holds the ALU operands
// in a single valid/ready output slot with flush.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W = operand_fetch_pkg::DATA_W,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_use_imm,
    input  logic [OP_W-1:0]   in_alu_op,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_A,
    output logic [DATA_W-1:0] out_B,
    output logic [OP_W-1:0]   out_alu_op,
    output logic [ADDR_W-1:0] out_rd
);

    logic [DATA_W-1:0] w_rdata1;
    logic [DATA_W-1:0] w_rdata2;
    logic              w_accept;
    logic              r_valid;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [OP_W-1:0]   r_op;
    logic [ADDR_W-1:0] r_rd;

    regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_raddr1 (in_rs1),
        .i_raddr2 (in_rs2),
        .o_rdata1 (w_rdata1),
        .o_rdata2 (w_rdata2),
        .i_we     (wb_en),
        .i_waddr  (wb_addr),
        .i_wdata  (wb_data)
    );

    assign in_ready = (!r_valid || out_ready) && !flush;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Payload only moves on an accept, so a stalled slot never re-reads the file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a  <= '0;
            r_b  <= '0;
            r_op <= '0;
            r_rd <= '0;
        end else if (w_accept) begin
            r_a  <= w_rdata1;
            r_b  <= in_use_imm ? in_imm : w_rdata2;
            r_op <= in_alu_op;
            r_rd <= in_rd;
        end
    end

    assign out_valid  = r_valid;
    assign out_A      = r_a;
    assign out_B      = r_b;
    assign out_alu_op = r_op;
    assign out_rd     = r_rd;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios followed by random
// traffic, all compared against an architectural model of registers and slot.
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inValid;
    logic        inReady;
    logic [4:0]  inRs1;
    logic [4:0]  inRs2;
    logic [31:0] inImm;
    logic        inUseImm;
    logic [2:0]  inAluOp;
    logic [4:0]  inRd;
    logic        wbEn;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;
    logic        flush;
    logic        outValid;
    logic        outReady;
    logic [31:0] outA;
    logic [31:0] outB;
    logic [2:0]  outAluOp;
    logic [4:0]  outRd;

    logic [31:0] mRegs [32];
    logic        mValid;
    logic [31:0] mA;
    logic [31:0] mB;
    logic [2:0]  mOp;
    logic [4:0]  mRd;

    int nTests = 0;
    int nFail  = 0;

    operand_fetch #(.DATA_W(32), .NREG(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .in_rs1     (inRs1),
        .in_rs2     (inRs2),
        .in_imm     (inImm),
        .in_use_imm (inUseImm),
        .in_alu_op  (inAluOp),
        .in_rd      (inRd),
        .wb_en      (wbEn),
        .wb_addr    (wbAddr),
        .wb_data    (wbData),
        .flush      (flush),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .out_A      (outA),
        .out_B      (outB),
        .out_alu_op (outAluOp),
        .out_rd     (outRd)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".out_valid"}, {31'b0, outValid}, {31'b0, mValid});
        checkOutput({tag, ".out_A"}, outA, mA);
        checkOutput({tag, ".out_B"}, outB, mB);
        checkOutput({tag, ".out_alu_op"}, {29'b0, outAluOp}, {29'b0, mOp});
        checkOutput({tag, ".out_rd"}, {27'b0, outRd}, {27'b0, mRd});
    endtask

    function automatic logic [31:0] readReg(input logic [4:0] r);
        if (r == 0) return 32'h0;
        if (wbEn && wbAddr == r) return wbData;
        return mRegs[r];
    endfunction

    function automatic void resetModel();
        for (int i = 0; i < 32; i++) mRegs[i] = '0;
        mValid = 1'b0;
        mA = '0; mB = '0; mOp = '0; mRd = '0;
    endfunction

    // One clock: check in_ready before the edge, advance the model, check the slot after.
    task automatic applyStimulus(input string tag);
        logic expReady;
        logic accept;
        logic [31:0] a;
        logic [31:0] b;
        #1;
        expReady = (!mValid || outReady) && !flush;
        checkOutput({tag, ".in_ready"}, {31'b0, inReady}, {31'b0, expReady});
        accept = inValid && expReady;
        a = readReg(inRs1);
        b = inUseImm ? inImm : readReg(inRs2);
        @(posedge clk);
        if (accept) begin
            mA = a; mB = b; mOp = inAluOp; mRd = inRd;
        end
        mValid = !flush && (accept || (mValid && !outReady));
        if (wbEn && wbAddr != 0) mRegs[wbAddr] = wbData;
        #1;
        checkAll(tag);
    endtask

    task automatic idleInputs();
        inValid = 0; inRs1 = 0; inRs2 = 0; inImm = 0; inUseImm = 0;
        inAluOp = 0; inRd = 0; wbEn = 0; wbAddr = 0; wbData = 0; flush = 0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] op,
                         input logic [4:0] rd);
        inValid = 1; inRs1 = rs1; inRs2 = rs2; inAluOp = op; inRd = rd;
    endtask

    logic [31:0] holdA, holdB;
    logic [4:0]  holdRd;

    initial begin
        idleInputs();
        outReady = 1;
        rst_n = 0;
        resetModel();
        #2;
        checkAll("reset");
        checkOutput("reset.in_ready", {31'b0, inReady}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1;

        wbEn = 1; wbAddr = 5; wbData = 32'd10;
        applyStimulus("wb5");
        wbAddr = 6; wbData = 32'd7;
        applyStimulus("wb6");
        wbEn = 0;
        issue(5, 6, ALU_OR, 9);
        applyStimulus("read56");
        checkOutput("read56.A", outA, 32'd10);
        checkOutput("read56.B", outB, 32'd7);

        issue(3, 0, ALU_ADD, 1);
        wbEn = 1; wbAddr = 3; wbData = 32'hDEAD;
        applyStimulus("bypass");
        checkOutput("bypass.A", outA, 32'hDEAD);

        inValid = 0; wbAddr = 0; wbData = 32'hFFFF;
        applyStimulus("wb0");
        wbEn = 0;
        issue(0, 3, ALU_SUB, 2);
        applyStimulus("read0");
        checkOutput("read0.A", outA, 32'h0);

        issue(5, 6, ALU_AND, 4);
        inUseImm = 1; inImm = 32'h7;
        applyStimulus("imm");
        checkOutput("imm.B", outB, 32'h7);
        inUseImm = 0;

        // Backpressure: slot stalls while its source register is rewritten.
        outReady = 0;
        issue(5, 6, ALU_XOR, 12);
        applyStimulus("bp.load");
        holdA = outA; holdB = outB; holdRd = outRd;
        issue(6, 5, ALU_ADD, 13);
        wbEn = 1; wbAddr = 5;
        for (int i = 0; i < 3; i++) begin
            wbData = 32'h100 + i;
            applyStimulus("bp.stall");
            checkOutput("bp.inReadyLow", {31'b0, inReady}, 32'd0);
            checkOutput("bp.holdA", outA, holdA);
            checkOutput("bp.holdB", outB, holdB);
            checkOutput("bp.holdRd", {27'b0, outRd}, {27'b0, holdRd});
        end
        wbEn = 0;
        outReady = 1;
        for (int i = 0; i < 6; i++) begin
            issue(5'(i), 5'(i + 1), 3'(i), 5'(20 + i));
            applyStimulus("stream");
            checkOutput("stream.valid", {31'b0, outValid}, 32'd1);
            checkOutput("stream.rd", {27'b0, outRd}, 32'(20 + i));
        end

        flush = 1;
        issue(5, 6, ALU_SLT, 30);
        applyStimulus("flush");
        checkOutput("flush.valid", {31'b0, outValid}, 32'd0);
        flush = 0; inValid = 0;
        applyStimulus("postflush");

        // Reset in the middle of a stall.
        outReady = 0;
        issue(5, 6, ALU_SLL, 17);
        applyStimulus("rst.load");
        applyStimulus("rst.stall");
        rst_n = 0;
        resetModel();
        #1;
        checkAll("rst.async");
        @(posedge clk); #1;
        rst_n = 1;
        inValid = 0; outReady = 1;
        #1;
        checkOutput("rst.inReady", {31'b0, inReady}, 32'd1);
        issue(5, 6, ALU_SRL, 3);
        applyStimulus("rst.read");
        checkOutput("rst.regA", outA, 32'h0);

        for (int i = 0; i < 300; i++) begin
            inValid  = 1'($urandom_range(0, 3) != 0);
            outReady = 1'($urandom_range(0, 3) != 0);
            flush    = 1'($urandom_range(0, 9) == 0);
            inRs1    = 5'($urandom_range(0, 7));
            inRs2    = 5'($urandom_range(0, 7));
            inImm    = $urandom;
            inUseImm = 1'($urandom_range(0, 1));
            inAluOp  = 3'($urandom_range(0, 7));
            inRd     = 5'($urandom_range(0, 31));
            wbEn     = 1'($urandom_range(0, 1));
            wbAddr   = 5'($urandom_range(0, 7));
            wbData   = $urandom;
            applyStimulus("rand");
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
